// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for 8-bit register ALU instructions. It reads A and the second
// operand, drives the ALU for ALU_LATENCY cycles, then writes back A and the flags.
module alu_issue_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int ALU_LATENCY = 1,
  parameter int A_INDEX     = 7
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [7:0]            i_opcode,
  input  logic [DATA_WIDTH-1:0] i_imm,
  output logic [2:0]            o_rf_raddr,
  input  logic [DATA_WIDTH-1:0] i_rf_rdata,
  output logic [DATA_WIDTH-1:0] o_alu_a,
  output logic [DATA_WIDTH-1:0] o_alu_b,
  output logic [2:0]            o_alu_ctrl,
  output logic [3:0]            o_alu_flags_in,
  input  logic [DATA_WIDTH-1:0] i_alu_data,
  input  logic [3:0]            i_alu_flags,
  output logic                  o_wb_en,
  output logic [DATA_WIDTH-1:0] o_wb_data,
  output logic [3:0]            o_flags,
  input  logic                  i_flags_we,
  input  logic [3:0]            i_flags_wdata,
  output logic                  o_done,
  output logic                  o_illegal
);

  localparam int CNT_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_EXEC,
    S_WB
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [5:0]            r_opcode;
  logic [DATA_WIDTH-1:0] r_imm;
  logic [DATA_WIDTH-1:0] r_op_a;
  logic [DATA_WIDTH-1:0] r_op_b;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_exec_first;
  logic [3:0]            r_flags;
  logic                  r_illegal;

  logic                  w_legal;
  logic                  w_use_imm;
  logic [2:0]            w_ooo;
  logic [DATA_WIDTH-1:0] w_b_src;
  logic [DATA_WIDTH-1:0] w_alu_b;

  assign w_legal   = (i_opcode[7:6] == 2'b10) ||
                     ((i_opcode[7:6] == 2'b11) && (i_opcode[2:0] == 3'b110));
  assign w_use_imm = (r_opcode[2:0] == 3'b110);
  assign w_ooo     = r_opcode[5:3];
  assign w_b_src   = w_use_imm ? r_imm : i_rf_rdata;
  // The register file answers one cycle after the RD_B address, so operand B is
  // forwarded straight through in the first EXEC cycle and held from then on.
  assign w_alu_b   = r_exec_first ? w_b_src : r_op_b;

  assign o_flags   = r_flags;
  assign o_illegal = r_illegal;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    w_next         = r_state;
    o_ready        = 1'b0;
    o_rf_raddr     = 3'd0;
    o_alu_a        = '0;
    o_alu_b        = '0;
    o_alu_ctrl     = 3'd0;
    o_alu_flags_in = 4'd0;
    o_wb_en        = 1'b0;
    o_wb_data      = '0;
    o_done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid && w_legal) w_next = S_RD_A;
      end
      S_RD_A: begin
        o_rf_raddr = 3'(A_INDEX);
        w_next     = S_RD_B;
      end
      S_RD_B: begin
        o_rf_raddr = r_opcode[2:0];
        w_next     = S_EXEC;
      end
      S_EXEC: begin
        o_alu_a        = r_op_a;
        o_alu_b        = w_alu_b;
        o_alu_ctrl     = w_ooo;
        o_alu_flags_in = r_flags;
        if (r_cnt == '0) w_next = S_WB;
      end
      S_WB: begin
        o_alu_a        = r_op_a;
        o_alu_b        = r_op_b;
        o_alu_ctrl     = w_ooo;
        o_alu_flags_in = r_flags;
        o_done         = 1'b1;
        // CP only compares: flags update, A is left untouched.
        if (w_ooo != 3'b111) begin
          o_wb_en   = 1'b1;
          o_wb_data = i_alu_data;
        end
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, since a mid-operation reset must
  // leave no stale operand or flag value visible.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_opcode     <= '0;
      r_imm        <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_cnt        <= '0;
      r_exec_first <= 1'b0;
      r_flags      <= 4'd0;
      r_illegal    <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_flags_we) r_flags <= i_flags_wdata;
          if (i_valid) begin
            r_opcode  <= i_opcode[5:0];
            r_imm     <= i_imm;
            r_illegal <= !w_legal;
          end
        end
        S_RD_B: begin
          r_op_a       <= i_rf_rdata;
          r_cnt        <= CNT_W'(ALU_LATENCY - 1);
          r_exec_first <= 1'b1;
        end
        S_EXEC: begin
          r_exec_first <= 1'b0;
          if (r_exec_first) r_op_b <= w_b_src;
          if (r_cnt != '0)  r_cnt  <= r_cnt - 1'b1;
        end
        S_WB: r_flags <= i_alu_flags;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: two instances, ALU_LATENCY 1 and 3, with a
// synchronous-read register-file model and constant ALU responses per vector.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst1, rst3;
  logic       valid;
  logic [7:0] opcode, imm;
  logic       flags_we;
  logic [3:0] flags_wdata;
  logic [7:0] alu_data;
  logic [3:0] alu_flags;

  logic       ready1, wb_en1, done1, illegal1;
  logic [2:0] raddr1, ctrl1;
  logic [7:0] rdata1, alu_a1, alu_b1, wb_data1;
  logic [3:0] fin1, flags1;

  logic       ready3, wb_en3, done3, illegal3;
  logic [2:0] raddr3, ctrl3;
  logic [7:0] rdata3, alu_a3, alu_b3, wb_data3;
  logic [3:0] fin3, flags3;

  logic [7:0] rf [8];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rdata1 <= rf[raddr1];
    rdata3 <= rf[raddr3];
  end

  alu_issue_ctrl #(.DATA_WIDTH(8), .ALU_LATENCY(1), .A_INDEX(7)) u_dut1 (
    .i_clk(clk), .i_rst(rst1), .i_valid(valid), .o_ready(ready1),
    .i_opcode(opcode), .i_imm(imm), .o_rf_raddr(raddr1), .i_rf_rdata(rdata1),
    .o_alu_a(alu_a1), .o_alu_b(alu_b1), .o_alu_ctrl(ctrl1), .o_alu_flags_in(fin1),
    .i_alu_data(alu_data), .i_alu_flags(alu_flags), .o_wb_en(wb_en1),
    .o_wb_data(wb_data1), .o_flags(flags1), .i_flags_we(flags_we),
    .i_flags_wdata(flags_wdata), .o_done(done1), .o_illegal(illegal1)
  );

  alu_issue_ctrl #(.DATA_WIDTH(8), .ALU_LATENCY(3), .A_INDEX(7)) u_dut3 (
    .i_clk(clk), .i_rst(rst3), .i_valid(valid), .o_ready(ready3),
    .i_opcode(opcode), .i_imm(imm), .o_rf_raddr(raddr3), .i_rf_rdata(rdata3),
    .o_alu_a(alu_a3), .o_alu_b(alu_b3), .o_alu_ctrl(ctrl3), .o_alu_flags_in(fin3),
    .i_alu_data(alu_data), .i_alu_flags(alu_flags), .o_wb_en(wb_en3),
    .o_wb_data(wb_data3), .o_flags(flags3), .i_flags_we(flags_we),
    .i_flags_wdata(flags_wdata), .o_done(done3), .o_illegal(illegal3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One instruction through the latency-1 instance, checked phase by phase.
  task automatic op1(input string name, input logic [7:0] opc, input logic [7:0] im,
                     input logic [7:0] ea, input logic [7:0] eb, input logic [3:0] efin,
                     input logic ewb, input logic [7:0] ewd, input logic [3:0] eflags,
                     input logic fwe_acc, input logic fwe_busy, input logic [3:0] fwd);
    @(negedge clk);
    valid = 1'b1; opcode = opc; imm = im;
    flags_we = fwe_acc; flags_wdata = fwd;
    @(negedge clk);                       // RD_A
    valid = 1'b0;
    flags_we = fwe_busy;
    check({name, " rd_a ready"}, 32'(ready1), 32'd0);
    check({name, " rd_a raddr"}, 32'(raddr1), 32'd7);
    @(negedge clk);                       // RD_B
    flags_we = 1'b0;
    check({name, " rd_b raddr"}, 32'(raddr1), 32'(opc[2:0]));
    @(negedge clk);                       // EXEC
    check({name, " alu_a"},    32'(alu_a1), 32'(ea));
    check({name, " alu_b"},    32'(alu_b1), 32'(eb));
    check({name, " alu_ctrl"}, 32'(ctrl1),  32'(opc[5:3]));
    check({name, " flags_in"}, 32'(fin1),   32'(efin));
    check({name, " exec done"}, 32'(done1), 32'd0);
    @(negedge clk);                       // WB
    check({name, " done"},    32'(done1),    32'd1);
    check({name, " wb_en"},   32'(wb_en1),   32'(ewb));
    check({name, " wb_data"}, 32'(wb_data1), 32'(ewd));
    @(negedge clk);                       // back in IDLE
    check({name, " flags"},     32'(flags1), 32'(eflags));
    check({name, " ready"},     32'(ready1), 32'd1);
    check({name, " idle alu_a"}, 32'(alu_a1), 32'd0);
    check({name, " idle done"},  32'(done1),  32'd0);
  endtask

  initial begin
    logic [7:0] bad_ops [3];
    bad_ops[0] = 8'h40; bad_ops[1] = 8'hC7; bad_ops[2] = 8'h3F;
    rst1 = 1'b1; rst3 = 1'b1;
    valid = 1'b0; opcode = 8'h00; imm = 8'h00;
    flags_we = 1'b0; flags_wdata = 4'h0;
    alu_data = 8'h00; alu_flags = 4'h0;
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;
    repeat (2) @(negedge clk);
    check("rst ready",   32'(ready1),   32'd1);
    check("rst flags",   32'(flags1),   32'd0);
    check("rst done",    32'(done1),    32'd0);
    check("rst illegal", 32'(illegal1), 32'd0);
    check("rst raddr",   32'(raddr1),   32'd0);
    check("rst alu_a",   32'(alu_a1),   32'd0);
    check("rst wb_en",   32'(wb_en1),   32'd0);
    check("rst3 ready",  32'(ready3),   32'd1);
    rst1 = 1'b0;

    // ADD B
    rf[7] = 8'h3A; rf[0] = 8'hC6; alu_data = 8'h00; alu_flags = 4'b1011;
    op1("add_b", 8'h80, 8'h00, 8'h3A, 8'hC6, 4'h0, 1'b1, 8'h00, 4'b1011, 1'b0, 1'b0, 4'h0);
    // SUB imm
    rf[7] = 8'h3E; alu_data = 8'h2F; alu_flags = 4'b0100;
    op1("sub_n", 8'hD6, 8'h0F, 8'h3E, 8'h0F, 4'b1011, 1'b1, 8'h2F, 4'b0100, 1'b0, 1'b0, 4'h0);
    // ADC (HL) with a flags write on the accepting edge
    alu_data = 8'h90; alu_flags = 4'b0000;
    op1("adc_hl", 8'h8E, 8'h55, 8'h3E, 8'h55, 4'h1, 1'b1, 8'h90, 4'b0000, 1'b1, 1'b0, 4'h1);
    // CP imm with a flags write attempted while busy
    alu_data = 8'h00; alu_flags = 4'b1100;
    op1("cp_n", 8'hFE, 8'h3E, 8'h3E, 8'h3E, 4'h0, 1'b0, 8'h00, 4'b1100, 1'b0, 1'b1, 4'hF);

    foreach (bad_ops[k]) begin
      @(negedge clk);
      valid = 1'b1; opcode = bad_ops[k];
      @(negedge clk);
      valid = 1'b0;
      check($sformatf("ill_%0h pulse", bad_ops[k]), 32'(illegal1), 32'd1);
      check($sformatf("ill_%0h ready", bad_ops[k]), 32'(ready1),   32'd1);
      check($sformatf("ill_%0h raddr", bad_ops[k]), 32'(raddr1),   32'd0);
      @(negedge clk);
      check($sformatf("ill_%0h end", bad_ops[k]),   32'(illegal1), 32'd0);
      check($sformatf("ill_%0h flags", bad_ops[k]), 32'(flags1),   32'(4'b1100));
      check($sformatf("ill_%0h raddr2", bad_ops[k]), 32'(raddr1),  32'd0);
    end

    // Latency-3 instance: ADD C, done 5 edges after accept.
    rst1 = 1'b1; rst3 = 1'b0;
    rf[7] = 8'h22; rf[1] = 8'h11; alu_data = 8'h33; alu_flags = 4'b0001;
    @(negedge clk);
    valid = 1'b1; opcode = 8'h81;
    @(negedge clk);
    valid = 1'b0;
    check("l3 rd_a raddr", 32'(raddr3), 32'd7);
    @(negedge clk);
    check("l3 rd_b raddr", 32'(raddr3), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("l3 exec%0d alu_a", i), 32'(alu_a3), 32'h22);
      check($sformatf("l3 exec%0d alu_b", i), 32'(alu_b3), 32'h11);
      check($sformatf("l3 exec%0d done", i),  32'(done3),  32'd0);
    end
    @(negedge clk);
    check("l3 done",    32'(done3),    32'd1);
    check("l3 wb_en",   32'(wb_en3),   32'd1);
    check("l3 wb_data", 32'(wb_data3), 32'h33);
    @(negedge clk);
    check("l3 flags", 32'(flags3), 32'(4'b0001));
    check("l3 ready", 32'(ready3), 32'd1);

    // Reset in the 2nd EXEC cycle aborts the instruction.
    valid = 1'b1; opcode = 8'h81;
    @(negedge clk);                       // RD_A
    valid = 1'b0;
    @(negedge clk);                       // RD_B
    @(negedge clk);                       // EXEC 1
    @(negedge clk);                       // EXEC 2
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    check("abort ready", 32'(ready3), 32'd1);
    check("abort flags", 32'(flags3), 32'd0);
    check("abort done",  32'(done3),  32'd0);
    check("abort wb_en", 32'(wb_en3), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("abort later%0d done", i),  32'(done3),  32'd0);
      check($sformatf("abort later%0d wb_en", i), 32'(wb_en3), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
